// File: rtl/stream_fanout_pkg.sv
// Shared definitions for the stream_fanout_page block: FSM state encoding
// and the layout of a queued token ({e, d}).
package stream_fanout_pkg;

  typedef enum logic {
    ST_DISPATCH = 1'b0,
    ST_BCAST    = 1'b1
  } state_t;

  // Data occupies the low DW bits of a token; the end-of-stream flag sits directly above it.
  localparam int TOK_D_LSB = 0;

  function automatic int tok_e_idx(input int dw);
    return TOK_D_LSB + dw;
  endfunction

endpackage

// File: rtl/stream_fanout_q.sv
// stream_fanout_q: DEPTH-entry token FIFO (DEPTH a power of two) with
// registered occupancy count. Push is ignored when full, pop when empty.
module stream_fanout_q
  import stream_fanout_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array: written on push, never reset (only the pointers matter).
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_fanout_page.sv
// stream_fanout_page: single input token stream fanned out round-robin to
// NCH output channels through per-channel one-entry register slices.
// End-of-stream tokens are broadcast to every channel before the pointer
// restarts at channel 0.
// Optional build macro STREAM_FANOUT_LEVEL_EN adds the q_level output
// (registered FIFO occupancy).
module stream_fanout_page
  import stream_fanout_pkg::*;
#(
  parameter int DW    = 9,
  parameter int NCH   = 8,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DW-1:0]     in_d,
  input  logic              in_e,
  input  logic              in_v,
  output logic              in_b,
  output logic [NCH*DW-1:0] out_d,
  output logic [NCH-1:0]    out_e,
  output logic [NCH-1:0]    out_v,
  input  logic [NCH-1:0]    out_b
`ifdef STREAM_FANOUT_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] q_level
`endif
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW    = DW + 1;
  localparam int E_IDX = tok_e_idx(DW);

  logic [TW-1:0]  w_tok_in;
  logic [TW-1:0]  w_head;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic           w_head_e;
  logic [DW-1:0]  w_head_d;
  logic [NCH-1:0] w_loadable;
  logic [NCH-1:0] w_load;
  logic           w_load_e;
  logic [PW-1:0]  w_ptr_nxt;

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [NCH-1:0] r_done;
  logic [NCH-1:0] r_v;
  logic [NCH-1:0] r_e;
  logic [NCH*DW-1:0] r_d;

  // Back-pressure is forced high during reset so nothing is accepted.
  assign in_b   = !reset || (w_count == CW'(DEPTH));
  assign w_push = in_v && reset && !w_full;

  // Pack the incoming token as {e, d}.
  always_comb begin
    w_tok_in                     = '0;
    w_tok_in[E_IDX]              = in_e;
    w_tok_in[TOK_D_LSB +: DW]    = in_d;
  end

  stream_fanout_q #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_q (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_tok_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef STREAM_FANOUT_LEVEL_EN
  assign q_level = w_count;
`endif

  assign w_head_e   = w_head[E_IDX];
  assign w_head_d   = w_head[TOK_D_LSB +: DW];
  assign w_loadable = ~r_v | ~out_b;
  assign w_ptr_nxt  = (r_ptr == PW'(NCH - 1)) ? '0 : r_ptr + 1'b1;

  // Decide which slices load this cycle and whether the FIFO head retires.
  always_comb begin
    w_load   = '0;
    w_pop    = 1'b0;
    w_load_e = 1'b0;
    case (r_state)
      ST_DISPATCH: begin
        if (!w_empty && !w_head_e && w_loadable[r_ptr]) begin
          w_load[r_ptr] = 1'b1;
          w_pop         = 1'b1;
        end
      end
      ST_BCAST: begin
        w_load   = w_loadable & ~r_done;
        w_load_e = 1'b1;
        // Retire the EOS in the same cycle the last channel takes its copy.
        w_pop    = &(r_done | w_load);
      end
      default: begin
        w_load = '0;
      end
    endcase
  end

  // Dispatch/broadcast FSM: round-robin pointer and broadcast done-mask.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_DISPATCH;
      r_ptr   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        ST_DISPATCH: begin
          if (!w_empty && w_head_e) begin
            r_state <= ST_BCAST;
            r_done  <= '0;
          end else if (w_pop) begin
            r_ptr <= w_ptr_nxt;
          end
        end
        ST_BCAST: begin
          if (w_pop) begin
            r_state <= ST_DISPATCH;
            r_ptr   <= '0;
            r_done  <= '0;
          end else begin
            r_done <= r_done | w_load;
          end
        end
        default: r_state <= ST_DISPATCH;
      endcase
    end
  end

  // Output register slices: load from the FIFO head, or empty when the consumer takes the token.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_v <= '0;
      r_e <= '0;
      r_d <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_load[i]) begin
          r_v[i]           <= 1'b1;
          r_e[i]           <= w_load_e;
          r_d[i*DW +: DW]  <= w_head_d;
        end else if (!out_b[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  assign out_v = r_v;
  assign out_e = r_e;
  assign out_d = r_d;

endmodule

// File: tb/tb_stream_fanout_page.sv
// Bench for stream_fanout_page: instance A uses default parameters for the
// directed scenarios, instance B (NCH=3, DW=12, DEPTH=8) takes random traffic.
// Expected tokens come from a sequence-level model: data tokens go to the
// next channel in round-robin order, EOS tokens go to every channel and
// restart the rotation at channel 0.
`timescale 1ns/1ps
module tb_stream_fanout_page;

  localparam int A_DW = 9,  A_NCH = 8, A_DEPTH = 4;
  localparam int B_DW = 12, B_NCH = 3, B_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [A_DW-1:0]       a_in_d;
  logic                  a_in_e, a_in_v, a_in_b;
  logic [A_NCH*A_DW-1:0] a_out_d;
  logic [A_NCH-1:0]      a_out_e, a_out_v, a_out_b;

  logic [B_DW-1:0]       b_in_d;
  logic                  b_in_e, b_in_v, b_in_b;
  logic [B_NCH*B_DW-1:0] b_out_d;
  logic [B_NCH-1:0]      b_out_e, b_out_v, b_out_b;

`ifdef STREAM_FANOUT_LEVEL_EN
  logic [2:0] a_q_level;
  logic [3:0] b_q_level;
`endif

  stream_fanout_page #(.DW(A_DW), .NCH(A_NCH), .DEPTH(A_DEPTH)) dut_a (
    .clock (clk), .reset (rst_n),
    .in_d  (a_in_d), .in_e (a_in_e), .in_v (a_in_v), .in_b (a_in_b),
    .out_d (a_out_d), .out_e (a_out_e), .out_v (a_out_v), .out_b (a_out_b)
`ifdef STREAM_FANOUT_LEVEL_EN
    , .q_level (a_q_level)
`endif
  );

  stream_fanout_page #(.DW(B_DW), .NCH(B_NCH), .DEPTH(B_DEPTH)) dut_b (
    .clock (clk), .reset (rst_n),
    .in_d  (b_in_d), .in_e (b_in_e), .in_v (b_in_v), .in_b (b_in_b),
    .out_d (b_out_d), .out_e (b_out_e), .out_v (b_out_v), .out_b (b_out_b)
`ifdef STREAM_FANOUT_LEVEL_EN
    , .q_level (b_q_level)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int expq [32][$];     // index inst*16 + channel; value = (e << 16) | d
  int mptr [2];
  int deliv [2];
  int eos_cnt [32];
  int a_stalls = 0;
  logic b_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sequence-level reference: where an accepted token must come out.
  function automatic void model_accept(input int inst, input int d, input bit e);
    int n;
    n = (inst == 0) ? A_NCH : B_NCH;
    if (e) begin
      for (int c = 0; c < n; c++) expq[inst*16 + c].push_back(32'h10000 | d);
      mptr[inst] = 0;
    end else begin
      expq[inst*16 + mptr[inst]].push_back(d);
      mptr[inst] = (mptr[inst] + 1) % n;
    end
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < 32; k++) if (expq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic score(input int inst, input int c, input int act);
    int k;
    int exp;
    k = inst*16 + c;
    n_cmp++;
    if (expq[k].size() == 0) begin
      n_bad++;
      $display("FAIL out%0d_ch%0d: got token %h, expected no token", inst, c, act);
    end else begin
      exp = expq[k].pop_front();
      if (act != exp) begin
        n_bad++;
        $display("FAIL out%0d_ch%0d: got token %h, expected %h", inst, c, act, exp);
      end
    end
    deliv[inst]++;
    if (act[16]) eos_cnt[k]++;
  endtask

  // Monitor: a transfer completes at the next rising edge when v=1 and b=0.
  always @(negedge clk) begin
    for (int c = 0; c < A_NCH; c++)
      if (a_out_v[c] && !a_out_b[c])
        score(0, c, {15'd0, a_out_e[c], 7'd0, a_out_d[c*A_DW +: A_DW]});
    for (int c = 0; c < B_NCH; c++)
      if (b_out_v[c] && !b_out_b[c])
        score(1, c, {15'd0, b_out_e[c], 4'd0, b_out_d[c*B_DW +: B_DW]});
  end

  // Random consumer back-pressure for instance B.
  initial begin
    b_out_b = '0;
    forever begin
      @(posedge clk); #1;
      b_out_b = b_rand ? 3'($urandom & $urandom) : 3'd0;
    end
  end

  // Present one token and hold it until accepted; expectation recorded at acceptance.
  task automatic send(input int inst, input int d, input bit e);
    int n;
    n = 0;
    if (inst == 0) begin a_in_d = 9'(d);  a_in_e = e; a_in_v = 1'b1; end
    else           begin b_in_d = 12'(d); b_in_e = e; b_in_v = 1'b1; end
    forever begin
      @(negedge clk);
      if ((inst == 0) ? !a_in_b : !b_in_b) begin
        model_accept(inst, d, e);
        break;
      end
      if (inst == 0) a_stalls++;
      n++;
      if (n > 2000) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    a_in_v = 1'b0;
    b_in_v = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    a_out_b = '0;
    while (!all_empty() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_all_delivered"}, int'(all_empty()), 1);
    chk({name, "_a_idle"}, int'(a_out_v), 0);
  endtask

  // Synchronous reset pulse with checks on the reset state and on release.
  task automatic do_reset(input string name);
    a_out_b = '1;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) begin
      expq[k].delete();
      eos_cnt[k] = 0;
    end
    mptr[0] = 0; mptr[1] = 0;
    deliv[0] = 0; deliv[1] = 0;
    chk({name, "_rst_a_out_v"}, int'(a_out_v), 0);
    chk({name, "_rst_b_out_v"}, int'(b_out_v), 0);
    chk({name, "_rst_a_out_e"}, int'(a_out_e), 0);
    chk({name, "_rst_a_out_d_zero"}, int'(a_out_d == '0), 1);
    chk({name, "_rst_a_in_b"}, int'(a_in_b), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk({name, "_rel_a_in_b"}, int'(a_in_b), 0);
    chk({name, "_rel_b_in_b"}, int'(b_in_b), 0);
`ifdef STREAM_FANOUT_LEVEL_EN
    chk({name, "_rel_q_level"}, int'(a_q_level), 0);
`endif
    a_out_b = '0;
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int neos;
    bit e;
    rst_n  = 1'b0;
    a_in_d = '0; a_in_e = 1'b0; a_in_v = 1'b0; a_out_b = '0;
    b_in_d = '0; b_in_e = 1'b0; b_in_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_a_out_v", int'(a_out_v), 0);
    chk("init_a_in_b", int'(a_in_b), 1);
    do_reset("t1");

    // Test 1: d=1..16 streamed back to back, no output stalls.
    a_in_d = 9'd1; a_in_e = 1'b0; a_in_v = 1'b1;
    @(negedge clk);
    chk("t1_first_in_b", int'(a_in_b), 0);
    model_accept(0, 1, 1'b0);
    @(posedge clk); #1;
    chk("t1_out_v_after_accept_edge", int'(a_out_v), 0);
    a_stalls = 0;
    send(0, 2, 1'b0);
    chk("t1_out_v0_two_edges_later", int'(a_out_v[0]), 1);
    for (int k = 3; k <= 16; k++) send(0, k, 1'b0);
    chk("t1_in_b_never_high", a_stalls, 0);
    drain("t1");

    // Test 2: channel 2 stalled while 16 tokens are offered.
    do_reset("t2");
    a_out_b = 8'h04;
    fork
      begin
        for (int k = 1; k <= 16; k++) send(0, k, 1'b0);
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        chk("t2_in_b_full", int'(a_in_b), 1);
        chk("t2_delivered_while_stalled", deliv[0], 9);
`ifdef STREAM_FANOUT_LEVEL_EN
        chk("t2_q_level_full", int'(a_q_level), 4);
`endif
        a_out_b = '0;
      end
    join
    drain("t2");

    // Test 3: data then EOS broadcast, then data restarts at channel 0.
    do_reset("t3");
    send(0, 5, 1'b0);
    send(0, 6, 1'b0);
    send(0, 7, 1'b0);
    send(0, 9'h1FF, 1'b1);
    send(0, 8, 1'b0);
    drain("t3");
    for (int c = 0; c < A_NCH; c++) chk($sformatf("t3_eos_ch%0d", c), eos_cnt[c], 1);

    // Test 4: EOS while channel 7 holds an unconsumed token.
    do_reset("t4");
    a_out_b = 8'h80;
    for (int k = 0; k < 8; k++) send(0, k, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    fork
      begin
        send(0, 9'h1AA, 1'b1);
        for (int k = 20; k < 25; k++) send(0, k, 1'b0);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        neos = 0;
        for (int c = 0; c < 7; c++) neos += eos_cnt[c];
        chk("t4_eos_ch0_6", neos, 7);
        chk("t4_eos_ch7_held", eos_cnt[7], 0);
        chk("t4_in_b_backed_up", int'(a_in_b), 1);
        a_out_b = '0;
      end
    join
    drain("t4");
    chk("t4_eos_ch7_after_release", eos_cnt[7], 1);

    // Test 5: reset in the middle of a broadcast with tokens queued.
    do_reset("t5a");
    a_out_b = 8'h80;
    for (int k = 0; k < 8; k++) send(0, k, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(0, 9'h1FF, 1'b1);
    send(0, 30, 1'b0);
    send(0, 31, 1'b0);
    send(0, 32, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_in_b_full_before_reset", int'(a_in_b), 1);
    do_reset("t5b");
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_stale_tokens", deliv[0], 0);
    chk("t5_out_v_idle", int'(a_out_v), 0);

    // Test 6: random traffic on instance B with random EOS.
    do_reset("t6");
    b_rand = 1'b1;
    neos = 0;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      e = (k == 999) || ($urandom_range(0, 24) == 0);
      if (e) neos++;
      send(1, e ? int'($urandom & 32'hFFF) : (k & 32'hFFF), e);
    end
    b_rand = 1'b0;
    drain("t6");
    for (int c = 0; c < B_NCH; c++) chk($sformatf("t6_eos_ch%0d", c), eos_cnt[16 + c], neos);
    chk("t6_b_idle", int'(b_out_v), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
